usb_ep_fifo_bank: RTL

Parametrised bank of transactional endpoint FIFOs. It exports the endpoint data paths between the USB protocol engine (`usb_pe`) and user logic. Each endpoint has one IN FIFO and one OUT FIFO:

- **IN FIFO:** user pushes; the PE pops speculatively.
- **OUT FIFO:** the PE fills speculatively; the user pops.

The PE side can commit or roll back a whole packet at transaction end, so a NAKed/timed-out IN or a corrupted OUT packet leaves the FIFO unchanged.

---
 rtl/usb_ep_pkg.sv | 21 ++
 rtl/usb_ep_fifo_bank_if.sv | 43 ++++
 rtl/usb_trans_fifo.sv | 99 +++++++++
 rtl/usb_ep_fifo_bank.sv | 54 +++++
 4 files changed

// File: rtl/usb_ep_pkg.sv
// Shared definitions for the USB endpoint FIFO bank and the protocol engine.
// Holds the default FIFO depth, the bus slicing helper and the transaction opcode.
package usb_ep_pkg;

    localparam int EP_FIFO_DEFAULT_ADDR_WID = 9;
    localparam int EP_DEFAULT_DATA_WID      = 8;

    // Pointer action taken at the end of a transaction; FLUSH dominates everything.
    typedef enum logic [1:0] {
        TR_IDLE,
        TR_COMMIT,
        TR_REWIND,
        TR_FLUSH
    } trans_op_e;

    // Bit offset of endpoint n inside a packed per-endpoint bus.
    function automatic int epSlice(input int n, input int data_wid = EP_DEFAULT_DATA_WID);
        return n * data_wid;
    endfunction

endpackage

// File: rtl/usb_ep_fifo_bank_if.sv
// Packed per-endpoint data paths between the PE/user side (master) and the FIFO bank (slave).
interface usb_ep_fifo_bank_if #(
    parameter int ENDPOINTS   = 2,
    parameter int EP_DATA_WID = 8
);
    logic                             usbResetFlush_i;
    logic [ENDPOINTS-1:0]             EP_IN_push_i;
    logic [EP_DATA_WID*ENDPOINTS-1:0] EP_IN_wrData_i;
    logic [ENDPOINTS-1:0]             EP_IN_full_o;
    logic [ENDPOINTS-1:0]             EP_IN_popData_i;
    logic [ENDPOINTS-1:0]             EP_IN_popTransDone_i;
    logic [ENDPOINTS-1:0]             EP_IN_popTransSuccess_i;
    logic [ENDPOINTS-1:0]             EP_IN_dataAvailable_o;
    logic [EP_DATA_WID*ENDPOINTS-1:0] EP_IN_data_o;
    logic [ENDPOINTS-1:0]             EP_OUT_dataValid_i;
    logic [ENDPOINTS-1:0]             EP_OUT_fillTransDone_i;
    logic [ENDPOINTS-1:0]             EP_OUT_fillTransSuccess_i;
    logic [ENDPOINTS-1:0]             EP_OUT_full_o;
    logic [EP_DATA_WID*ENDPOINTS-1:0] EP_OUT_data_i;
    logic [ENDPOINTS-1:0]             EP_OUT_pop_i;
    logic [ENDPOINTS-1:0]             EP_OUT_dataAvailable_o;
    logic [EP_DATA_WID*ENDPOINTS-1:0] EP_OUT_rdData_o;

    modport master (
        output usbResetFlush_i,
        output EP_IN_push_i, EP_IN_wrData_i, EP_IN_popData_i,
        output EP_IN_popTransDone_i, EP_IN_popTransSuccess_i,
        output EP_OUT_dataValid_i, EP_OUT_fillTransDone_i, EP_OUT_fillTransSuccess_i,
        output EP_OUT_data_i, EP_OUT_pop_i,
        input  EP_IN_full_o, EP_IN_dataAvailable_o, EP_IN_data_o,
        input  EP_OUT_full_o, EP_OUT_dataAvailable_o, EP_OUT_rdData_o
    );

    modport slave (
        input  usbResetFlush_i,
        input  EP_IN_push_i, EP_IN_wrData_i, EP_IN_popData_i,
        input  EP_IN_popTransDone_i, EP_IN_popTransSuccess_i,
        input  EP_OUT_dataValid_i, EP_OUT_fillTransDone_i, EP_OUT_fillTransSuccess_i,
        input  EP_OUT_data_i, EP_OUT_pop_i,
        output EP_IN_full_o, EP_IN_dataAvailable_o, EP_IN_data_o,
        output EP_OUT_full_o, EP_OUT_dataAvailable_o, EP_OUT_rdData_o
    );
endinterface

// File: rtl/usb_trans_fifo.sv
// Transactional FIFO: the speculative side (read for IN, write for OUT) can be committed
// or rewound as a whole packet; the other side behaves like a plain FIFO port.
module usb_trans_fifo
    import usb_ep_pkg::*;
#(
    parameter int DATA_WID      = 8,
    parameter int ADDR_WID      = EP_FIFO_DEFAULT_ADDR_WID,
    parameter bit TRANS_ON_READ = 1'b1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_flush,
    input  logic                i_push,
    input  logic [DATA_WID-1:0] i_push_data,
    input  logic                i_pop,
    input  logic                i_trans_done,
    input  logic                i_trans_success,
    output logic                o_full,
    output logic                o_avail,
    output logic [DATA_WID-1:0] o_data
);
    localparam int DEPTH = 1 << ADDR_WID;
    typedef logic [ADDR_WID:0] ptr_t;
    localparam ptr_t FULL_DIST = ptr_t'(DEPTH);

    // The non-transactional side keeps its commit pointer locked to its spec pointer,
    // so full/avail can be written once for both directions.
    ptr_t r_wr_spec, r_wr_commit, r_rd_spec, r_rd_commit;
    ptr_t w_wr_spec, w_wr_commit, w_rd_spec, w_rd_commit;
    ptr_t w_wr_inc, w_rd_inc;
    logic w_full, w_avail, w_push_ok, w_pop_ok;
    trans_op_e w_op;

    logic [DATA_WID-1:0] r_mem [DEPTH];

    assign w_full    = ptr_t'(r_wr_spec - r_rd_commit) == FULL_DIST;
    assign w_avail   = r_rd_spec != r_wr_commit;
    assign w_push_ok = i_push & ~w_full;
    assign w_pop_ok  = i_pop & w_avail;
    assign w_wr_inc  = r_wr_spec + ptr_t'(w_push_ok);
    assign w_rd_inc  = r_rd_spec + ptr_t'(w_pop_ok);

    always_comb begin
        if (i_flush)           w_op = TR_FLUSH;
        else if (!i_trans_done) w_op = TR_IDLE;
        else if (i_trans_success) w_op = TR_COMMIT;
        else                   w_op = TR_REWIND;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        w_wr_spec   = w_wr_inc;
        w_rd_spec   = w_rd_inc;
        w_wr_commit = TRANS_ON_READ ? w_wr_inc : r_wr_commit;
        w_rd_commit = TRANS_ON_READ ? r_rd_commit : w_rd_inc;
        unique case (w_op)
            TR_FLUSH: begin
                w_wr_spec   = '0;
                w_wr_commit = '0;
                w_rd_spec   = '0;
                w_rd_commit = '0;
            end
            TR_COMMIT: begin
                if (TRANS_ON_READ) w_rd_commit = w_rd_inc;
                else               w_wr_commit = w_wr_inc;
            end
            TR_REWIND: begin
                if (TRANS_ON_READ) w_rd_spec = r_rd_commit;
                else               w_wr_spec = r_wr_commit;
            end
            default: ;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all pointers update together.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_spec   <= '0;
            r_wr_commit <= '0;
            r_rd_spec   <= '0;
            r_rd_commit <= '0;
        end else begin
            r_wr_spec   <= w_wr_spec;
            r_wr_commit <= w_wr_commit;
            r_rd_spec   <= w_rd_spec;
            r_rd_commit <= w_rd_commit;
        end
    end

    // NOTE: the storage array has no reset; contents only matter behind valid pointers.
    always_ff @(posedge i_clk) begin
        if (w_push_ok) r_mem[r_wr_spec[ADDR_WID-1:0]] <= i_push_data;
    end

    assign o_full  = w_full;
    assign o_avail = w_avail;
    assign o_data  = r_mem[r_rd_spec[ADDR_WID-1:0]];

endmodule

// File: rtl/usb_ep_fifo_bank.sv
// Bank of per-endpoint IN/OUT transactional FIFOs between the USB PE and user logic.
module usb_ep_fifo_bank
    import usb_ep_pkg::*;
#(
    parameter int ENDPOINTS   = 2,
    parameter int EP_DATA_WID = 8,
    parameter int EP_ADDR_WID = EP_FIFO_DEFAULT_ADDR_WID
) (
    input  logic                 clk48_i,
    input  logic                 rst_i,
    usb_ep_fifo_bank_if.slave    bus
);

    for (genvar n = 0; n < ENDPOINTS; n++) begin : g_ep
        localparam int LSB = epSlice(n, EP_DATA_WID);

        usb_trans_fifo #(
            .DATA_WID      (EP_DATA_WID),
            .ADDR_WID      (EP_ADDR_WID),
            .TRANS_ON_READ (1'b1)
        ) u_in_fifo (
            .i_clk           (clk48_i),
            .i_rst           (rst_i),
            .i_flush         (bus.usbResetFlush_i),
            .i_push          (bus.EP_IN_push_i[n]),
            .i_push_data     (bus.EP_IN_wrData_i[LSB +: EP_DATA_WID]),
            .i_pop           (bus.EP_IN_popData_i[n]),
            .i_trans_done    (bus.EP_IN_popTransDone_i[n]),
            .i_trans_success (bus.EP_IN_popTransSuccess_i[n]),
            .o_full          (bus.EP_IN_full_o[n]),
            .o_avail         (bus.EP_IN_dataAvailable_o[n]),
            .o_data          (bus.EP_IN_data_o[LSB +: EP_DATA_WID])
        );

        usb_trans_fifo #(
            .DATA_WID      (EP_DATA_WID),
            .ADDR_WID      (EP_ADDR_WID),
            .TRANS_ON_READ (1'b0)
        ) u_out_fifo (
            .i_clk           (clk48_i),
            .i_rst           (rst_i),
            .i_flush         (bus.usbResetFlush_i),
            .i_push          (bus.EP_OUT_dataValid_i[n]),
            .i_push_data     (bus.EP_OUT_data_i[LSB +: EP_DATA_WID]),
            .i_pop           (bus.EP_OUT_pop_i[n]),
            .i_trans_done    (bus.EP_OUT_fillTransDone_i[n]),
            .i_trans_success (bus.EP_OUT_fillTransSuccess_i[n]),
            .o_full          (bus.EP_OUT_full_o[n]),
            .o_avail         (bus.EP_OUT_dataAvailable_o[n]),
            .o_data          (bus.EP_OUT_rdData_o[LSB +: EP_DATA_WID])
        );
    end

endmodule
